pattern_grader: RTL and testbench
=================================

PATTERN_GRADER -- requirements
Module: pattern_grader

Interface
REQ-001 SHALL have parameter NUM_POS, 4, number of shape positions per pattern (2..8).
REQ-002 SHALL have parameter SHAPE_W, 3, bits per shape code.
REQ-003 SHALL have parameter NUM_SHAPES, 6, valid shape codes 1..NUM_SHAPES; code 0 is blank.
REQ-004 SHALL have parameter MAX_ROUNDS, 8, guesses allowed per game.
REQ-005 SHALL have derived widths: CW = $clog2(NUM_POS+1) and RW = $clog2(MAX_ROUNDS+1).
REQ-006 SHALL have one clock and an asynchronous, active-high reset:
- CLOCK_50  in  1  clock.
- reset  in  1  asynchronous active-high reset.
REQ-007 SHALL have the remaining ports (name, direction, width, meaning):
- Guess  in  NUM_POS*SHAPE_W  guess; position 0 occupies the MSBs.
- masterPattern  in  NUM_POS*SHAPE_W  secret pattern, same packing as Guess.
- GradeIt  in  1  grade request.
- NewGame  in  1  synchronous game restart.
- Busy  out  1  grading in progress.
- GradeDone  out  1  one-cycle result-valid pulse.
- Znarly  out  CW  count of right shape in right position.
- Zood  out  CW  count of right shape in wrong position.
- RoundNumber  out  RW  guesses graded this game.
- Win  out  1  last grade was all Znarly.
- GameOver  out  1  no further grades are accepted.

Function
REQ-008 SHALL implement the FSM states IDLE, COUNT, FINISH and DONE.
REQ-009 IDLE: a GradeIt sampled high with GameOver=0 and NewGame=0 SHALL capture Guess and masterPattern into internal registers, clear the accumulator, set the shape index to 1, and go to COUNT.
REQ-010 COUNT: each edge SHALL add min(count of index in guess, count of index in master) to the accumulator and increment the index; the edge that processes index NUM_SHAPES SHALL go to FINISH.
REQ-011 FINISH: the next edge SHALL load Znarly = number of positions where the captured values are equal and in 1..NUM_SHAPES.
REQ-012 FINISH: the same edge SHALL load Zood = accumulator minus Znarly.
REQ-013 FINISH: the same edge SHALL increment RoundNumber, load Win = (Znarly==NUM_POS), and go to DONE.
REQ-014 DONE SHALL assert GradeDone for exactly one cycle, then return to IDLE.
REQ-015 Latency: with GradeIt sampled at edge E0, GradeDone SHALL be high in the cycle after edge E(NUM_SHAPES+1).
REQ-016 Busy SHALL be 1 in COUNT and FINISH and 0 otherwise.
REQ-017 Guess and masterPattern changes after capture SHALL NOT affect the result.
REQ-018 GradeIt SHALL be ignored outside IDLE and while GameOver=1, with no GradeDone produced.
REQ-019 Codes 0 or greater than NUM_SHAPES SHALL never contribute to Znarly or Zood.
REQ-020 Znarly, Zood and Win SHALL hold their values until the next FINISH load or a clear.
REQ-021 Znarly+Zood SHALL never exceed NUM_POS, and no arithmetic SHALL wrap.
REQ-022 GameOver SHALL be registered and equal Win OR (RoundNumber==MAX_ROUNDS).
REQ-023 RoundNumber SHALL saturate at MAX_ROUNDS.
REQ-024 NewGame high at an edge SHALL clear RoundNumber, Znarly, Zood, Win, GameOver and the accumulator, and force IDLE.
REQ-025 NewGame SHALL abort any grade in progress without producing GradeDone.
REQ-026 NewGame SHALL take priority over a simultaneous GradeIt, and that GradeIt SHALL be dropped.

Reset
REQ-027 reset high SHALL asynchronously force IDLE and clear all outputs, the capture registers, the accumulator and the index to 0, including mid-grade.
REQ-028 After reset deasserts, the first GradeIt SHALL be accepted on the next edge.

Verification
REQ-029 Defaults, Guess=5,5,3,5 and master=1,1,5,3, GradeIt pulse -> GradeDone 8 cycles later, Znarly=0, Zood=2, RoundNumber=1, Win=0.
REQ-030 Guess=1,3,2,1 and master=1,1,5,3 -> Znarly=1, Zood=2; Guess=1,1,1,1 and master=1,1,1,1 -> Znarly=4, Zood=0, Win=1, GameOver=1, and a further GradeIt produces no GradeDone.
REQ-031 Eight non-winning grades -> RoundNumber=8, GameOver=1, and a ninth GradeIt is ignored; NewGame then returns RoundNumber=0 and GameOver=0.
REQ-032 GradeIt held high throughout and Guess changed during COUNT -> exactly one GradeDone per grade, and results match the captured values.
REQ-033 reset, or NewGame, asserted in COUNT -> Busy=0 next cycle, no GradeDone, and all outputs 0.
REQ-034 NUM_POS=6, NUM_SHAPES=6, Guess=0,0,1,2,3,4 and master=0,0,4,3,2,1 -> Znarly=0, Zood=4.

Source files
------------

// File: rtl/pattern_grader.sv
// pattern_grader: grades a guessed shape pattern against a secret pattern.
// Znarly counts exact position matches; Zood counts right shapes in the
// wrong place.  Shape-count minima are accumulated one shape code per cycle,
// so a grade takes NUM_SHAPES+2 cycles from request to the GradeDone pulse.
module pattern_grader #(
  parameter  int NUM_POS    = 4,
  parameter  int SHAPE_W    = 3,
  parameter  int NUM_SHAPES = 6,
  parameter  int MAX_ROUNDS = 8,
  localparam int CW         = $clog2(NUM_POS + 1),
  localparam int RW         = $clog2(MAX_ROUNDS + 1)
) (
  input  logic                       CLOCK_50,
  input  logic                       reset,
  input  logic [NUM_POS*SHAPE_W-1:0] Guess,
  input  logic [NUM_POS*SHAPE_W-1:0] masterPattern,
  input  logic                       GradeIt,
  input  logic                       NewGame,
  output logic                       Busy,
  output logic                       GradeDone,
  output logic [CW-1:0]              Znarly,
  output logic [CW-1:0]              Zood,
  output logic [RW-1:0]              RoundNumber,
  output logic                       Win,
  output logic                       GameOver
);

  localparam int PW = NUM_POS * SHAPE_W;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_COUNT  = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [SHAPE_W-1:0] MAX_CODE = SHAPE_W'(NUM_SHAPES);
  localparam logic [SHAPE_W-1:0] IDX_ONE  = SHAPE_W'(1);
  localparam logic [RW-1:0]      MAX_RND  = RW'(MAX_ROUNDS);
  localparam logic [CW-1:0]      ALL_POS  = CW'(NUM_POS);

  // Number of positions of pat holding the given code.
  function automatic logic [CW-1:0] f_count_code(input logic [PW-1:0] pat,
                                                 input logic [SHAPE_W-1:0] code);
    logic [CW-1:0] cnt;
    cnt = {CW{1'b0}};
    for (int p = 0; p < NUM_POS; p++) begin
      if (pat[(NUM_POS-1-p)*SHAPE_W +: SHAPE_W] == code) begin
        cnt = cnt + CW'(1);
      end else begin
        cnt = cnt;
      end
    end
    return cnt;
  endfunction

  // Positions where both patterns carry the same valid (non-blank, in-range) code.
  function automatic logic [CW-1:0] f_count_exact(input logic [PW-1:0] g,
                                                  input logic [PW-1:0] m);
    logic [CW-1:0]      cnt;
    logic [SHAPE_W-1:0] gc;
    logic [SHAPE_W-1:0] mc;
    cnt = {CW{1'b0}};
    for (int p = 0; p < NUM_POS; p++) begin
      gc = g[(NUM_POS-1-p)*SHAPE_W +: SHAPE_W];
      mc = m[(NUM_POS-1-p)*SHAPE_W +: SHAPE_W];
      if ((gc == mc) && (gc != {SHAPE_W{1'b0}}) && (gc <= MAX_CODE)) begin
        cnt = cnt + CW'(1);
      end else begin
        cnt = cnt;
      end
    end
    return cnt;
  endfunction

  logic [1:0]         r_state;
  logic [PW-1:0]      r_guess;
  logic [PW-1:0]      r_master;
  logic [CW-1:0]      r_acc;
  logic [SHAPE_W-1:0] r_idx;
  logic               r_busy;
  logic               r_done;
  logic [CW-1:0]      r_znarly;
  logic [CW-1:0]      r_zood;
  logic [RW-1:0]      r_round;
  logic               r_win;
  logic               r_over;

  logic [CW-1:0]      w_cnt_g;
  logic [CW-1:0]      w_cnt_m;
  logic [CW-1:0]      w_idx_min;
  logic [CW-1:0]      w_znarly;
  logic [RW-1:0]      w_round_inc;
  logic               w_win;

  // Per-shape minimum, exact-match count and saturated round for the datapath.
  always_comb begin
    w_cnt_g   = f_count_code(r_guess, r_idx);
    w_cnt_m   = f_count_code(r_master, r_idx);
    w_idx_min = (w_cnt_g < w_cnt_m) ? w_cnt_g : w_cnt_m;
    w_znarly  = f_count_exact(r_guess, r_master);
    w_win     = (w_znarly == ALL_POS);
    if (r_round == MAX_RND) begin
      w_round_inc = r_round;
    end else begin
      w_round_inc = r_round + RW'(1);
    end
  end

  // Grading FSM, capture registers and registered result outputs.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_guess  <= {PW{1'b0}};
      r_master <= {PW{1'b0}};
      r_acc    <= {CW{1'b0}};
      r_idx    <= {SHAPE_W{1'b0}};
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_znarly <= {CW{1'b0}};
      r_zood   <= {CW{1'b0}};
      r_round  <= {RW{1'b0}};
      r_win    <= 1'b0;
      r_over   <= 1'b0;
    end else if (NewGame) begin
      // Restart wins over everything, including a grade in flight.
      r_state  <= S_IDLE;
      r_acc    <= {CW{1'b0}};
      r_idx    <= {SHAPE_W{1'b0}};
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_znarly <= {CW{1'b0}};
      r_zood   <= {CW{1'b0}};
      r_round  <= {RW{1'b0}};
      r_win    <= 1'b0;
      r_over   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (GradeIt && !r_over) begin
            r_guess  <= Guess;
            r_master <= masterPattern;
            r_acc    <= {CW{1'b0}};
            r_idx    <= IDX_ONE;
            r_busy   <= 1'b1;
            r_state  <= S_COUNT;
          end else begin
            r_busy   <= 1'b0;
          end
        end
        S_COUNT: begin
          r_acc <= r_acc + w_idx_min;
          r_idx <= r_idx + IDX_ONE;
          if (r_idx == MAX_CODE) begin
            r_state <= S_FINISH;
          end else begin
            r_state <= S_COUNT;
          end
        end
        S_FINISH: begin
          // Every exact match was also counted in the accumulator, so no underflow.
          r_znarly <= w_znarly;
          r_zood   <= r_acc - w_znarly;
          r_win    <= w_win;
          r_round  <= w_round_inc;
          r_over   <= w_win || (w_round_inc == MAX_RND);
          r_busy   <= 1'b0;
          r_done   <= 1'b1;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign Busy        = r_busy;
  assign GradeDone   = r_done;
  assign Znarly      = r_znarly;
  assign Zood        = r_zood;
  assign RoundNumber = r_round;
  assign Win         = r_win;
  assign GameOver    = r_over;

endmodule

// File: tb/tb_pattern_grader.sv
// Scoreboard bench for pattern_grader: expected results are computed by a
// greedy matching model, queued when a grade is requested and compared when
// GradeDone pulses.
module tb_pattern_grader;

  localparam int NP = 4;

  logic        clk;
  logic        reset;
  logic [11:0] Guess;
  logic [11:0] masterPattern;
  logic        GradeIt;
  logic        NewGame;
  logic        Busy;
  logic        GradeDone;
  logic [2:0]  Znarly;
  logic [2:0]  Zood;
  logic [3:0]  RoundNumber;
  logic        Win;
  logic        GameOver;

  logic [17:0] g6;
  logic [17:0] m6;
  logic        gi6;
  logic        ng6;
  logic        busy6;
  logic        done6;
  logic [2:0]  zn6;
  logic [2:0]  zo6;
  logic [3:0]  rnd6;
  logic        win6;
  logic        over6;

  pattern_grader u_dut (
    .CLOCK_50(clk), .reset(reset), .Guess(Guess), .masterPattern(masterPattern),
    .GradeIt(GradeIt), .NewGame(NewGame), .Busy(Busy), .GradeDone(GradeDone),
    .Znarly(Znarly), .Zood(Zood), .RoundNumber(RoundNumber), .Win(Win),
    .GameOver(GameOver)
  );

  pattern_grader #(.NUM_POS(6)) u_dut6 (
    .CLOCK_50(clk), .reset(reset), .Guess(g6), .masterPattern(m6),
    .GradeIt(gi6), .NewGame(ng6), .Busy(busy6), .GradeDone(done6),
    .Znarly(zn6), .Zood(zo6), .RoundNumber(rnd6), .Win(win6),
    .GameOver(over6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int zn;
    int zo;
    int rnd;
    int win;
    int over;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_done   = 0;
  int   m_round  = 0;
  int   m_over   = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] pack4(input int a, input int b, input int c, input int d);
    logic [2:0] x0, x1, x2, x3;
    x0 = a[2:0]; x1 = b[2:0]; x2 = c[2:0]; x3 = d[2:0];
    return {x0, x1, x2, x3};
  endfunction

  // Greedy reference: exact matches first, then pair leftover guess shapes
  // with unused leftover master shapes of the same valid code.
  task automatic model_score(input logic [11:0] g, input logic [11:0] m,
                             output int zn, output int zo);
    int gc[NP];
    int mc[NP];
    bit ex[NP];
    bit used[NP];
    zn = 0;
    zo = 0;
    for (int p = 0; p < NP; p++) begin
      gc[p] = int'(g[(NP-1-p)*3 +: 3]);
      mc[p] = int'(m[(NP-1-p)*3 +: 3]);
      ex[p] = (gc[p] == mc[p]) && (gc[p] >= 1) && (gc[p] <= 6);
      used[p] = 1'b0;
      if (ex[p]) zn++;
    end
    for (int p = 0; p < NP; p++) begin
      if (!ex[p] && gc[p] >= 1 && gc[p] <= 6) begin
        for (int q = 0; q < NP; q++) begin
          if (!ex[q] && !used[q] && mc[q] == gc[p]) begin
            used[q] = 1'b1;
            zo++;
            break;
          end
        end
      end
    end
  endtask

  task automatic push_expect(input logic [11:0] g, input logic [11:0] m, output int zn);
    exp_t e;
    int zo;
    model_score(g, m, zn, zo);
    e.zn  = zn;
    e.zo  = zo;
    m_round = (m_round < 8) ? m_round + 1 : 8;
    e.rnd = m_round;
    e.win = (zn == NP) ? 1 : 0;
    e.over = (e.win == 1 || m_round == 8) ? 1 : 0;
    m_over = e.over;
    sb_q.push_back(e);
  endtask

  // Compare every result pulse against the scoreboard head.
  always @(negedge clk) begin
    if (GradeDone === 1'b1) begin
      n_done++;
      if (sb_q.size() == 0) begin
        check_eq("unexpected_done", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check_eq("znarly", int'(Znarly), mon_e.zn);
        check_eq("zood", int'(Zood), mon_e.zo);
        check_eq("round", int'(RoundNumber), mon_e.rnd);
        check_eq("win", int'(Win), mon_e.win);
        check_eq("gameover", int'(GameOver), mon_e.over);
        check_eq("busy_at_done", int'(Busy), 0);
      end
    end
  end

  task automatic start_grade(input logic [11:0] g, input logic [11:0] m);
    @(negedge clk);
    Guess = g;
    masterPattern = m;
    GradeIt = 1'b1;
    @(posedge clk);
    #1;
    GradeIt = 1'b0;
  endtask

  task automatic grade(input logic [11:0] g, input logic [11:0] m);
    int zn;
    int k;
    push_expect(g, m, zn);
    start_grade(g, m);
    for (k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) check_eq("busy_in_count", int'(Busy), 1);
      if (GradeDone === 1'b1) break;
    end
    check_eq("latency", k, 7);
    @(negedge clk);
    #1;
  endtask

  task automatic check_cleared(input string tag);
    check_eq({tag, "_busy"}, int'(Busy), 0);
    check_eq({tag, "_done"}, int'(GradeDone), 0);
    check_eq({tag, "_znarly"}, int'(Znarly), 0);
    check_eq({tag, "_zood"}, int'(Zood), 0);
    check_eq({tag, "_round"}, int'(RoundNumber), 0);
    check_eq({tag, "_win"}, int'(Win), 0);
    check_eq({tag, "_over"}, int'(GameOver), 0);
  endtask

  task automatic no_done_for(input string tag, input int n0);
    repeat (12) @(posedge clk);
    #1;
    check_eq(tag, n_done, n0);
  endtask

  task automatic try_ignored(input string tag);
    int n0;
    n0 = n_done;
    @(negedge clk);
    GradeIt = 1'b1;
    @(posedge clk);
    #1;
    check_eq({tag, "_busy"}, int'(Busy), 0);
    @(negedge clk);
    GradeIt = 1'b0;
    no_done_for({tag, "_nodone"}, n0);
  endtask

  task automatic new_game();
    @(negedge clk);
    NewGame = 1'b1;
    @(negedge clk);
    NewGame = 1'b0;
    m_round = 0;
    m_over = 0;
    #1;
  endtask

  initial begin
    logic [11:0] rg, rm, ga, ma;
    int zn, zo, n0, k;
    Guess = 12'd0; masterPattern = 12'd0; GradeIt = 1'b0; NewGame = 1'b0;
    g6 = 18'd0; m6 = 18'd0; gi6 = 1'b0; ng6 = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_cleared("reset");
    @(negedge clk);
    reset = 1'b0;

    // Basic grades, then a win that ends the game.
    grade(pack4(5, 5, 3, 5), pack4(1, 1, 5, 3));
    grade(pack4(1, 3, 2, 1), pack4(1, 1, 5, 3));
    grade(pack4(1, 1, 1, 1), pack4(1, 1, 1, 1));
    try_ignored("after_win");
    new_game();
    check_cleared("newgame1");

    // Eight non-winning grades exhaust the game.
    for (int i = 0; i < 8; i++) begin
      rg = 12'($urandom);
      rm = 12'($urandom);
      model_score(rg, rm, zn, zo);
      if (zn == NP) rg[11:9] = 3'd0;
      grade(rg, rm);
    end
    check_eq("round_max", int'(RoundNumber), 8);
    check_eq("over_max", int'(GameOver), 1);
    try_ignored("ninth");
    new_game();
    check_eq("ng_round", int'(RoundNumber), 0);
    check_eq("ng_over", int'(GameOver), 0);

    // GradeIt held high while inputs change after capture.
    ga = pack4(2, 4, 6, 0);
    ma = pack4(4, 2, 6, 7);
    push_expect(ga, ma, zn);
    n0 = n_done;
    @(negedge clk);
    Guess = ga; masterPattern = ma; GradeIt = 1'b1;
    @(posedge clk);
    for (k = 1; k <= 20; k++) begin
      @(negedge clk);
      Guess = 12'($urandom);
      masterPattern = 12'($urandom);
      @(posedge clk);
      #1;
      if (GradeDone === 1'b1) break;
    end
    check_eq("held_latency", k, 7);
    GradeIt = 1'b0;
    no_done_for("held_one_done", n0 + 1);

    // NewGame aborts a grade in COUNT.
    start_grade(pack4(1, 2, 3, 4), pack4(4, 3, 2, 1));
    n0 = n_done;
    repeat (2) @(posedge clk);
    @(negedge clk);
    NewGame = 1'b1;
    @(posedge clk);
    #1;
    check_cleared("ng_abort");
    @(negedge clk);
    NewGame = 1'b0;
    m_round = 0; m_over = 0;
    no_done_for("ng_abort_nodone", n0);

    // NewGame beats a simultaneous GradeIt.
    n0 = n_done;
    @(negedge clk);
    GradeIt = 1'b1; NewGame = 1'b1;
    @(posedge clk);
    #1;
    check_eq("ng_prio_busy", int'(Busy), 0);
    @(negedge clk);
    GradeIt = 1'b0; NewGame = 1'b0;
    no_done_for("ng_prio_nodone", n0);

    // Asynchronous reset in COUNT, then an immediate grade.
    grade(pack4(1, 3, 2, 1), pack4(1, 1, 5, 3));
    start_grade(pack4(6, 5, 4, 3), pack4(3, 4, 5, 6));
    n0 = n_done;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_cleared("async_reset");
    @(negedge clk);
    reset = 1'b0;
    m_round = 0; m_over = 0;
    no_done_for("reset_nodone", n0);
    grade(pack4(6, 5, 4, 3), pack4(3, 4, 5, 6));

    // Six-position variant with blanks in matching positions.
    @(negedge clk);
    g6 = {3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    m6 = {3'd0, 3'd0, 3'd4, 3'd3, 3'd2, 3'd1};
    gi6 = 1'b1;
    @(posedge clk);
    #1;
    gi6 = 1'b0;
    for (k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (done6 === 1'b1) break;
    end
    check_eq("p6_latency", k, 7);
    check_eq("p6_znarly", int'(zn6), 0);
    check_eq("p6_zood", int'(zo6), 4);
    check_eq("queue_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
